// File: rtl/demux_rr_sched.sv
// Scheduler for a 1:8 word demultiplexer. It holds one word and steers it to a channel chosen
// round-robin over the enabled channels or by an explicit destination.
module demux_rr_sched #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic [2:0]    in_dest,
  output logic          in_ready,
  input  logic          mode,
  input  logic [7:0]    ch_en,
  output logic [2:0]    sel,
  output logic [7:0]    out_valid,
  output logic [DW-1:0] out_data,
  input  logic [7:0]    out_ready,
  output logic [7:0]    skip_cnt,
  output logic [7:0]    drop_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t        state_q, state_d;
  logic [2:0]    sel_q, sel_d;
  logic [2:0]    last_q, last_d;
  logic [DW-1:0] data_q, data_d;
  logic          mode_q, mode_d;
  logic [7:0]    wait_q, wait_d;
  logic [7:0]    skip_q, skip_d;
  logic [7:0]    drop_q, drop_d;
  logic [7:0]    valid_q, valid_d;

  logic          transfer_s;
  logic          accept_s;
  logic          rr_blocked_s;
  logic [2:0]    last_eff_s;

  // First enabled channel strictly after 'from', wrapping; 'from' itself is tried last.
  function automatic logic [2:0] next_enabled(input logic [7:0] mask, input logic [2:0] from);
    logic [2:0] idx;
    logic [2:0] res;
    logic       found;
    res   = from;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx   = from + 3'(k);
      res   = (!found && mask[idx]) ? idx : res;
      found = found | mask[idx];
    end
    return res;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [7:0] one_hot(input logic [2:0] ch);
    return 8'd1 << ch;
  endfunction

  // Handshake terms; a word finishing this cycle moves the round-robin pointer before selection.
  always_comb begin
    transfer_s   = (state_q == ST_SEND) && out_ready[sel_q];
    rr_blocked_s = (mode == 1'b0) && (ch_en == 8'h00);
    in_ready     = ((state_q == ST_IDLE) || transfer_s) && !rr_blocked_s;
    accept_s     = in_valid && in_ready;
    last_eff_s   = transfer_s ? sel_q : last_q;
  end

  // Next-state and datapath decisions.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_eff_s;
    data_d  = data_q;
    mode_d  = mode_q;
    wait_d  = wait_q;
    skip_d  = skip_q;
    drop_d  = drop_q;
    if (accept_s) begin
      data_d = in_data;
      mode_d = mode;
      wait_d = 8'd0;
      if (mode == 1'b0) begin
        sel_d   = next_enabled(ch_en, last_eff_s);
        state_d = ST_SEND;
      end else if (ch_en[in_dest]) begin
        sel_d   = in_dest;
        state_d = ST_SEND;
      end else begin
        drop_d  = sat_inc(drop_q);
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_SEND: begin
          if (transfer_s) begin
            state_d = ST_IDLE;
          end else if (!ch_en[sel_q]) begin
            // Channel disabled under a held word: addressed words are lost, RR words move on.
            if (mode_q) begin
              drop_d  = sat_inc(drop_q);
              state_d = ST_IDLE;
            end else if (ch_en != 8'h00) begin
              sel_d  = next_enabled(ch_en, sel_q);
              wait_d = 8'd0;
            end else begin
              sel_d = sel_q;
            end
          end else if (!mode_q) begin
            if ((wait_q + 8'd1) == TIMEOUT_C) begin
              sel_d  = next_enabled(ch_en, sel_q);
              skip_d = sat_inc(skip_q);
              wait_d = 8'd0;
            end else begin
              wait_d = wait_q + 8'd1;
            end
          end else begin
            wait_d = wait_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    valid_d = (state_d == ST_SEND) ? one_hot(sel_d) : 8'h00;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= 3'd0;
      last_q  <= 3'd7;
      data_q  <= '0;
      mode_q  <= 1'b0;
      wait_q  <= 8'd0;
      skip_q  <= 8'd0;
      drop_q  <= 8'd0;
      valid_q <= 8'h00;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      wait_q  <= wait_d;
      skip_q  <= skip_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
    end
  end

  assign sel       = sel_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign skip_cnt  = skip_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_demux_rr_sched.sv
// Bench for demux_rr_sched: directed scenarios plus random traffic, all checked every cycle
// against a channel-level reference model.
module tb_demux_rr_sched;

  localparam int DW      = 8;
  localparam int TIMEOUT = 15;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [2:0]    in_dest;
  logic          in_ready;
  logic          mode;
  logic [7:0]    ch_en;
  logic [2:0]    sel;
  logic [7:0]    out_valid;
  logic [DW-1:0] out_data;
  logic [7:0]    out_ready;
  logic [7:0]    skip_cnt;
  logic [7:0]    drop_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int cyc    = 0;

  // Reference model state: what the scheduler holds, where, and what it has counted.
  bit         m_held;
  logic [2:0] m_ch;
  logic [2:0] m_last;
  logic [7:0] m_data;
  bit         m_mode;
  int         m_wait;
  int         m_skip;
  int         m_drop;

  // Observation log of delivered words.
  int log_ch[$];
  int log_dat[$];
  int log_cyc[$];
  int ch0_cnt;
  int vcnt;

  demux_rr_sched #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_dest(in_dest),
    .in_ready(in_ready), .mode(mode), .ch_en(ch_en), .sel(sel), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .skip_cnt(skip_cnt), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] model_next(input logic [7:0] mask, input int from);
    for (int k = 1; k <= 8; k++) begin
      if (mask[(from + k) % 8]) return 3'((from + k) % 8);
    end
    return 3'(from);
  endfunction

  function automatic bit model_ready();
    return (!m_held || out_ready[m_ch]) && !(mode == 1'b0 && ch_en == 8'h00);
  endfunction

  // Reference model: advance one clock using the inputs presented for this edge.
  always @(posedge clk) begin
    bit xfer;
    bit acc;
    cyc++;
    if (!rst_n) begin
      m_held = 1'b0; m_ch = 3'd0; m_last = 3'd7; m_data = 8'h00;
      m_mode = 1'b0; m_wait = 0;  m_skip = 0;    m_drop = 0;
    end else begin
      xfer = m_held && out_ready[m_ch];
      acc  = in_valid && model_ready();
      if (xfer) m_last = m_ch;
      if (acc) begin
        m_data = in_data;
        if (mode == 1'b0) begin
          m_ch = model_next(ch_en, m_last); m_held = 1'b1; m_mode = 1'b0; m_wait = 0;
        end else if (ch_en[in_dest]) begin
          m_ch = in_dest; m_held = 1'b1; m_mode = 1'b1; m_wait = 0;
        end else begin
          if (m_drop < 255) m_drop++;
          m_held = 1'b0;
        end
      end else if (xfer) begin
        m_held = 1'b0;
      end else if (m_held) begin
        if (!ch_en[m_ch]) begin
          if (m_mode) begin
            if (m_drop < 255) m_drop++;
            m_held = 1'b0;
          end else if (ch_en != 8'h00) begin
            m_ch = model_next(ch_en, m_ch); m_wait = 0;
          end
        end else if (!m_mode) begin
          m_wait++;
          if (m_wait == TIMEOUT) begin
            m_ch = model_next(ch_en, m_ch);
            if (m_skip < 255) m_skip++;
            m_wait = 0;
          end
        end
      end
    end
  end

  // Compare process: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), m_held ? 32'(8'd1 << m_ch) : 32'd0);
      chk("sel", 32'(sel), 32'(m_ch));
      chk("skip_cnt", 32'(skip_cnt), 32'(m_skip));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      chk("in_ready", 32'(in_ready), 32'(model_ready()));
      if (m_held) chk("out_data", 32'(out_data), 32'(m_data));
      if ((out_valid & out_ready) != 8'h00) begin
        log_ch.push_back(int'(sel));
        log_dat.push_back(int'(out_data));
        log_cyc.push_back(cyc);
      end
      if (out_valid[0]) ch0_cnt++;
      if (out_valid != 8'h00) vcnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic clear_log();
    log_ch.delete();
    log_dat.delete();
    log_cyc.delete();
    ch0_cnt = 0;
    vcnt    = 0;
  endtask

  task automatic send_one(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_dest = 3'd0;
    mode = 1'b0; ch_en = 8'hFF; out_ready = 8'hFF;
    tick();
    do_reset();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset sel", 32'(sel), 32'd0);
    tick();

    // 1: round-robin, everything enabled and ready, back-to-back stream
    do_reset(); clear_log();
    ch_en = 8'hFF; out_ready = 8'hFF; mode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 8'hA0 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    ticks(3);
    chk("t1 count", 32'(log_ch.size()), 32'd10);
    for (int i = 0; i < 10 && i < log_ch.size(); i++) begin
      chk("t1 channel", 32'(log_ch[i]), 32'(i % 8));
      chk("t1 data", 32'(log_dat[i]), 32'(8'hA0 + i));
      chk("t1 cycle", 32'(log_cyc[i] - log_cyc[0]), 32'(i));
    end

    // 2: sparse enable mask, then an empty mask blocks acceptance
    do_reset(); clear_log();
    ch_en = 8'b0010_0101;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'h50 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    ticks(3);
    chk("t2 count", 32'(log_ch.size()), 32'd4);
    if (log_ch.size() == 4) begin
      chk("t2 ch a", 32'(log_ch[0]), 32'd0);
      chk("t2 ch b", 32'(log_ch[1]), 32'd2);
      chk("t2 ch c", 32'(log_ch[2]), 32'd5);
      chk("t2 ch d", 32'(log_ch[3]), 32'd0);
    end
    ch_en = 8'h00; in_valid = 1'b1;
    @(negedge clk);
    chk("t2 ready with empty mask", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0; ch_en = 8'hFF;
    ticks(2);

    // 3: channel 0 stalled, word skips to channel 1 after the timeout
    do_reset(); clear_log();
    ch_en = 8'hFF; out_ready = 8'hFE; mode = 1'b0;
    send_one(8'h33);
    ticks(30);
    chk("t3 ch0 cycles", 32'(ch0_cnt), 32'(TIMEOUT));
    chk("t3 skip_cnt", 32'(skip_cnt), 32'd1);
    chk("t3 count", 32'(log_ch.size()), 32'd1);
    if (log_ch.size() == 1) begin
      chk("t3 channel", 32'(log_ch[0]), 32'd1);
      chk("t3 data", 32'(log_dat[0]), 32'h33);
    end

    // 4: addressed word waits on a stalled channel without skipping
    do_reset(); clear_log();
    ch_en = 8'hFF; out_ready = 8'hBF; mode = 1'b1; in_dest = 3'd6;
    send_one(8'h44);
    ticks(40);
    chk("t4 not delivered", 32'(log_ch.size()), 32'd0);
    chk("t4 skip_cnt", 32'(skip_cnt), 32'd0);
    chk("t4 still valid", 32'(out_valid), 32'h40);
    out_ready = 8'hFF;
    ticks(3);
    chk("t4 count", 32'(log_ch.size()), 32'd1);
    if (log_ch.size() == 1) chk("t4 channel", 32'(log_ch[0]), 32'd6);

    // 5: addressed to a disabled channel, drops saturate
    do_reset(); clear_log();
    ch_en = 8'hF7; mode = 1'b1; in_dest = 3'd3;
    send_one(8'h55);
    ticks(3);
    chk("t5 drop one", 32'(drop_cnt), 32'd1);
    chk("t5 never valid", 32'(vcnt), 32'd0);
    in_valid = 1'b1;
    ticks(300);
    in_valid = 1'b0;
    tick();
    chk("t5 drop saturated", 32'(drop_cnt), 32'd255);

    // 6: reset while a word is held
    do_reset(); clear_log();
    ch_en = 8'hFF; out_ready = 8'h00; mode = 1'b0;
    send_one(8'h66);
    ticks(20);
    chk("t6 skip before reset", 32'(skip_cnt), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6 out_valid", 32'(out_valid), 32'd0);
    chk("t6 skip_cnt", 32'(skip_cnt), 32'd0);
    chk("t6 drop_cnt", 32'(drop_cnt), 32'd0);
    tick();
    clear_log();
    out_ready = 8'hFF;
    send_one(8'h67);
    ticks(3);
    chk("t6 count", 32'(log_ch.size()), 32'd1);
    if (log_ch.size() == 1) chk("t6 channel", 32'(log_ch[0]), 32'd0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_dest   = 3'($urandom);
      mode      = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 9) < 2) ? 8'h00 : 8'($urandom | $urandom);
      if ($urandom_range(0, 24) == 0) begin
        case ($urandom_range(0, 3))
          0: ch_en = 8'hFF;
          1: ch_en = 8'h00;
          2: ch_en = 8'd1 << $urandom_range(0, 7);
          default: ch_en = 8'($urandom);
        endcase
      end
      rst_n = ($urandom_range(0, 599) != 0);
      tick();
    end
    rst_n = 1'b1; in_valid = 1'b0;
    ticks(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
